reglk_guarded_regfile: RTL and testbench
========================================

REGLK_GUARDED_REGFILE -- requirements
Module: reglk_guarded_regfile

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of 32-bit guarded registers (legal 1..192).
REQ-002 SHALL have parameter CNT_W, default 8, violation counter width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni  input  1  synchronous, active-low reset.
REQ-005 SHALL have port reglk_i  input  32 x 6 (unpacked [5:0])  register-lock words; 1 = locked.
REQ-006 SHALL have port dbg_unlock_i  input  1  debug override; 1 = ignore locks.
REQ-007 SHALL have ports req_i  input  1; we_i  input  1; addr_i  input  8; wdata_i  input  32: access request.
REQ-008 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-009 SHALL have ports rvalid_o  output  1; rdata_o  output  32; err_o  output  1: response.
REQ-010 SHALL have port rready_i  input  1  response consumed.
REQ-011 SHALL have ports viol_cnt_o  output  CNT_W; viol_o  output  1 (sticky); viol_clr_i  input  1.

Function
REQ-012 SHALL implement FSM IDLE -> CHECK -> RESP -> IDLE.
REQ-013 In IDLE, gnt_o SHALL equal req_i combinationally; on req_i=1 the block SHALL capture we_i, addr_i, wdata_i and go to CHECK.
REQ-014 gnt_o SHALL be 0 in CHECK and RESP.
REQ-015 Lock bit for register k SHALL be reglk_i[k/32][k%32], sampled in the CHECK cycle, not at grant.
REQ-016 In CHECK, address >= NREGS SHALL set err=1, rdata=0, no register change.
REQ-017 In CHECK, write to a locked register with dbg_unlock_i=0 SHALL set err=1, suppress the write, count a violation.
REQ-018 In CHECK, write to an unlocked register (or dbg_unlock_i=1) SHALL update it at the CHECK->RESP edge, err=0, rdata=0.
REQ-019 Reads SHALL ignore locks: legal-address read returns register value in rdata, err=0.
REQ-020 rvalid_o SHALL assert in RESP (two cycles after the grant cycle) with rdata_o/err_o stable until rready_i=1; RESP -> IDLE on rready_i=1.
REQ-021 rvalid_o=0 SHALL force rdata_o=0 and err_o=0.
REQ-022 Out-of-range accesses SHALL NOT count as violations.
REQ-023 Violation counter SHALL increment by 1 per locked-write violation and saturate at 2^CNT_W-1.
REQ-024 viol_o SHALL set on first violation and remain 1 until viol_clr_i.
REQ-025 viol_clr_i SHALL zero counter and viol_o next cycle; if a violation occurs in the same cycle, counter SHALL become 1 and viol_o 1.
REQ-026 Lock changes during RESP SHALL NOT affect an already-issued response.

Reset
REQ-027 With rst_ni=0 at a rising edge: all NREGS registers 0, FSM IDLE, counter 0, viol_o 0, captured request cleared.
REQ-028 During and after reset, gnt_o follows REQ-013 from IDLE; rvalid_o, rdata_o, err_o SHALL be 0.
REQ-029 Reset asserted in the CHECK cycle SHALL dominate: no register write and no counter increment occur.
REQ-030 Reset asserted in RESP SHALL drop the pending response without rready_i.

Verification
REQ-031 Reset, reglk_i all 0, write 0xDEADBEEF to addr 3, then read addr 3 -> write resp err=0; read rdata=0xDEADBEEF, rvalid 2 cycles after grant.
REQ-032 reglk_i[0]=0x00000008, write 0x1234 to addr 3 -> err=1, addr 3 unchanged, viol_cnt_o=1, viol_o=1; repeat with dbg_unlock_i=1 -> err=0, addr 3=0x1234, count stays 1.
REQ-033 Read addr 40 with NREGS=32 -> err=1, rdata=0, viol_cnt_o unchanged.
REQ-034 256 locked writes with CNT_W=8 -> viol_cnt_o=255; then viol_clr_i coincident with a locked write -> viol_cnt_o=1, viol_o=1.
REQ-035 Hold rready_i=0 for 5 cycles in RESP while toggling reglk_i -> rvalid_o, rdata_o, err_o stable; gnt_o=0 throughout.
REQ-036 Assert rst_ni=0 in the CHECK cycle of an unlocked write of 0xFFFFFFFF to addr 0 -> addr 0 reads 0, no response issued.

Source files
------------

// File: rtl/reglk_guarded_regfile.sv
// Lock-guarded register file: each access is granted in IDLE, checked against the
// register-lock words in CHECK, and answered in RESP until the response is consumed.
module reglk_guarded_regfile #(
  parameter int NREGS = 32,
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       reglk_i [5:0],
  input  logic              dbg_unlock_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [7:0]        addr_i,
  input  logic [31:0]       wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  input  logic              rready_i,
  output logic [CNT_W-1:0]  viol_cnt_o,
  output logic              viol_o,
  input  logic              viol_clr_i,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a request is accepted in any cycle where req_i && gnt_o; the response
  // is held while rvalid_o && !rready_i and retires on the edge where both are 1.
  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, RESP = 2'd2} state_e;

  localparam logic [8:0] NREGS_W = 9'(NREGS);

  state_e             state_q;
  logic               we_q;
  logic [7:0]         addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               viol_q, viol_d;
  logic [31:0]        regs_q [NREGS];

  logic               in_range;
  logic               lock_bit;
  logic               wr_ok;
  logic               viol_ev;
  logic [31:0]        rd_val;

  always_comb begin
    in_range = ({1'b0, addr_q} < NREGS_W);
    lock_bit = 1'b0;
    // Lock words are read live in CHECK, so a lock raised after grant still blocks.
    if (in_range) lock_bit = reglk_i[addr_q[7:5]][addr_q[4:0]];
    wr_ok   = (state_q == CHECK) && in_range && we_q && (!lock_bit || dbg_unlock_i);
    viol_ev = (state_q == CHECK) && in_range && we_q && lock_bit && !dbg_unlock_i;
    rd_val  = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (addr_q == 8'(k)) rd_val = regs_q[k];
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    viol_d = viol_q;
    if (viol_clr_i) begin
      cnt_d  = viol_ev ? CNT_W'(1) : '0;
      viol_d = viol_ev;
    end else if (viol_ev) begin
      cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      viol_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      viol_q  <= 1'b0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      viol_q <= viol_d;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          for (int k = 0; k < NREGS; k++) begin
            if (wr_ok && addr_q == 8'(k)) regs_q[k] <= wdata_q;
          end
          err_q   <= !in_range || viol_ev;
          rdata_q <= (in_range && !we_q) ? rd_val : '0;
          state_q <= RESP;
        end
        RESP: begin
          if (rready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o       = (state_q == IDLE) && req_i;
  assign rvalid_o    = (state_q == RESP);
  assign rdata_o     = rvalid_o ? rdata_q : '0;
  assign err_o       = rvalid_o && err_q;
  assign viol_cnt_o  = cnt_q;
  assign viol_o      = viol_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_reglk_guarded_regfile.sv
// Directed bench for reglk_guarded_regfile (NREGS=32, CNT_W=8) with hand-computed expectations.
module tb_reglk_guarded_regfile;

  logic        clk;
  logic        rst_ni;
  logic [31:0] reglk_i [5:0];
  logic        dbg_unlock_i;
  logic        req_i, we_i;
  logic [7:0]  addr_i;
  logic [31:0] wdata_i;
  logic        gnt_o, rvalid_o, err_o, rready_i;
  logic [31:0] rdata_o;
  logic [7:0]  viol_cnt_o;
  logic        viol_o, viol_clr_i;
  logic [1:0]  dbg_state_o;

  int n_vec = 0;
  int n_err = 0;

  reglk_guarded_regfile #(.NREGS(32), .CNT_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .reglk_i(reglk_i), .dbg_unlock_i(dbg_unlock_i),
    .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .rready_i(rready_i),
    .viol_cnt_o(viol_cnt_o), .viol_o(viol_o), .viol_clr_i(viol_clr_i),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: starts just after a rising edge in IDLE, ends just after the retiring edge.
  // clr/lk0 are applied to viol_clr_i / reglk_i[0] for the CHECK cycle.
  task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                        input logic clr, input logic [31:0] lk0,
                        output logic g, output int lat, output logic [31:0] rd, output logic e);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
    @(negedge clk); g = gnt_o;
    @(posedge clk); #1;
    req_i = 1'b0; we_i = 1'b0; viol_clr_i = clr; reglk_i[0] = lk0;
    lat = 1;
    @(negedge clk);
    while (!rvalid_o && lat < 10) begin
      @(posedge clk); #1; viol_clr_i = 1'b0; lat++;
      @(negedge clk);
    end
    rd = rvalid_o ? rdata_o : 32'hxxxx_xxxx;
    e  = err_o;
    rready_i = 1'b1;
    @(posedge clk); #1;
    rready_i = 1'b0; viol_clr_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_i = 1'b1; we_i = 1'b0; addr_i = 8'd0; wdata_i = '0;
    dbg_unlock_i = 1'b0; rready_i = 1'b0; viol_clr_i = 1'b0;
    for (int i = 0; i < 6; i++) reglk_i[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++; if (gnt_o !== 1'b1) begin n_err++; $display("FAIL rst_gnt: got %0b exp 1", gnt_o); end
    n_vec++; if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0) begin n_err++;
      $display("FAIL rst_resp: got rvalid=%0b rdata=%h err=%0b exp 0/0/0", rvalid_o, rdata_o, err_o); end
    n_vec++; if (viol_cnt_o !== 8'd0 || viol_o !== 1'b0) begin n_err++;
      $display("FAIL rst_viol: got cnt=%0d viol=%0b exp 0/0", viol_cnt_o, viol_o); end
    n_vec++; if (dbg_state_o !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d exp 0", dbg_state_o); end
    @(posedge clk); #1 req_i = 1'b0; rst_ni = 1'b1;
  endtask

  task automatic test_write_read();
    logic g, e; int lat; logic [31:0] rd;
    access(1'b1, 8'd3, 32'hDEADBEEF, 1'b0, 32'h0, g, lat, rd, e);
    n_vec++; if (g !== 1'b1) begin n_err++; $display("FAIL wr3_gnt: got %0b exp 1", g); end
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL wr3_latency: got %0d exp 2", lat); end
    n_vec++; if (e !== 1'b0 || rd !== 32'h0) begin n_err++; $display("FAIL wr3_resp: got err=%0b rdata=%h exp 0/0", e, rd); end
    access(1'b0, 8'd3, 32'h0, 1'b0, 32'h0, g, lat, rd, e);
    n_vec++; if (lat != 2) begin n_err++; $display("FAIL rd3_latency: got %0d exp 2", lat); end
    n_vec++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin n_err++; $display("FAIL rd3_data: got %h err=%0b exp deadbeef/0", rd, e); end
    @(negedge clk);
    n_vec++; if (rdata_o !== 32'h0 || err_o !== 1'b0) begin n_err++;
      $display("FAIL idle_rdata_zero: got %h err=%0b exp 0/0", rdata_o, err_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_locked_write();
    logic g, e; int lat; logic [31:0] rd;
    reglk_i[0] = 32'h0000_0008;
    access(1'b1, 8'd3, 32'h1234, 1'b0, 32'h8, g, lat, rd, e);
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL lk_wr_err: got %0b exp 1", e); end
    n_vec++; if (viol_cnt_o !== 8'd1 || viol_o !== 1'b1) begin n_err++;
      $display("FAIL lk_wr_viol: got cnt=%0d viol=%0b exp 1/1", viol_cnt_o, viol_o); end
    access(1'b0, 8'd3, 32'h0, 1'b0, 32'h8, g, lat, rd, e);
    n_vec++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin n_err++; $display("FAIL lk_rd_unchanged: got %h err=%0b exp deadbeef/0", rd, e); end
    dbg_unlock_i = 1'b1;
    access(1'b1, 8'd3, 32'h1234, 1'b0, 32'h8, g, lat, rd, e);
    dbg_unlock_i = 1'b0;
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL dbg_wr_err: got %0b exp 0", e); end
    n_vec++; if (viol_cnt_o !== 8'd1) begin n_err++; $display("FAIL dbg_wr_cnt: got %0d exp 1", viol_cnt_o); end
    access(1'b0, 8'd3, 32'h0, 1'b0, 32'h8, g, lat, rd, e);
    n_vec++; if (rd !== 32'h1234) begin n_err++; $display("FAIL dbg_rd: got %h exp 00001234", rd); end
    access(1'b1, 8'd4, 32'h55, 1'b0, 32'h8, g, lat, rd, e);
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL nbr_wr_err: got %0b exp 0", e); end
    access(1'b0, 8'd4, 32'h0, 1'b0, 32'h8, g, lat, rd, e);
    n_vec++; if (rd !== 32'h55) begin n_err++; $display("FAIL nbr_rd: got %h exp 00000055", rd); end
  endtask

  task automatic test_out_of_range();
    logic g, e; int lat; logic [31:0] rd;
    reglk_i[1] = 32'hFFFF_FFFF;
    access(1'b0, 8'd40, 32'h0, 1'b0, 32'hFFFF_FFFF, g, lat, rd, e);
    n_vec++; if (e !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL oor_rd: got err=%0b rdata=%h exp 1/0", e, rd); end
    access(1'b1, 8'd40, 32'h77, 1'b0, 32'hFFFF_FFFF, g, lat, rd, e);
    n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL oor_wr_err: got %0b exp 1", e); end
    n_vec++; if (viol_cnt_o !== 8'd1) begin n_err++; $display("FAIL oor_cnt: got %0d exp 1", viol_cnt_o); end
    access(1'b1, 8'd31, 32'hCAFE_0031, 1'b0, 32'h0, g, lat, rd, e);
    access(1'b0, 8'd31, 32'h0, 1'b0, 32'h0, g, lat, rd, e);
    n_vec++; if (rd !== 32'hCAFE_0031 || e !== 1'b0) begin n_err++; $display("FAIL last_reg_rd: got %h err=%0b exp cafe0031/0", rd, e); end
    access(1'b1, 8'd31, 32'h1, 1'b0, 32'h8000_0000, g, lat, rd, e);
    n_vec++; if (e !== 1'b1 || viol_cnt_o !== 8'd2) begin n_err++;
      $display("FAIL last_reg_lock: got err=%0b cnt=%0d exp 1/2", e, viol_cnt_o); end
    reglk_i[1] = '0; reglk_i[0] = '0;
  endtask

  task automatic test_lock_sample();
    logic g, e; int lat; logic [31:0] rd;
    access(1'b1, 8'd5, 32'h77, 1'b0, 32'h20, g, lat, rd, e);
    n_vec++; if (e !== 1'b1 || viol_cnt_o !== 8'd3) begin n_err++;
      $display("FAIL late_lock: got err=%0b cnt=%0d exp 1/3", e, viol_cnt_o); end
    reglk_i[0] = 32'h20;
    access(1'b1, 8'd5, 32'h99, 1'b0, 32'h0, g, lat, rd, e);
    n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL late_unlock: got %0b exp 0", e); end
    access(1'b0, 8'd5, 32'h0, 1'b0, 32'h0, g, lat, rd, e);
    n_vec++; if (rd !== 32'h99) begin n_err++; $display("FAIL lock_sample_rd: got %h exp 00000099", rd); end
  endtask

  task automatic test_saturation();
    logic g, e; int lat; logic [31:0] rd;
    viol_clr_i = 1'b1; @(posedge clk); #1 viol_clr_i = 1'b0;
    @(negedge clk);
    n_vec++; if (viol_cnt_o !== 8'd0 || viol_o !== 1'b0) begin n_err++;
      $display("FAIL clr: got cnt=%0d viol=%0b exp 0/0", viol_cnt_o, viol_o); end
    @(posedge clk); #1;
    reglk_i[0] = 32'h8;
    for (int i = 0; i < 256; i++) begin
      access(1'b1, 8'd3, 32'(i), 1'b0, 32'h8, g, lat, rd, e);
      if (i == 254) begin
        n_vec++; if (viol_cnt_o !== 8'd255) begin n_err++; $display("FAIL cnt_255: got %0d exp 255", viol_cnt_o); end
      end
    end
    n_vec++; if (viol_cnt_o !== 8'd255 || viol_o !== 1'b1) begin n_err++;
      $display("FAIL cnt_sat: got cnt=%0d viol=%0b exp 255/1", viol_cnt_o, viol_o); end
    access(1'b1, 8'd3, 32'h0, 1'b1, 32'h8, g, lat, rd, e);
    n_vec++; if (viol_cnt_o !== 8'd1 || viol_o !== 1'b1 || e !== 1'b1) begin n_err++;
      $display("FAIL clr_with_viol: got cnt=%0d viol=%0b err=%0b exp 1/1/1", viol_cnt_o, viol_o, e); end
    access(1'b0, 8'd3, 32'h0, 1'b0, 32'h8, g, lat, rd, e);
    n_vec++; if (rd !== 32'h1234) begin n_err++; $display("FAIL sat_rd: got %h exp 00001234", rd); end
    reglk_i[0] = '0;
  endtask

  task automatic test_resp_hold();
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'd3;
    @(posedge clk); #1 req_i = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      reglk_i[0] = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      reglk_i[1] = 32'h0101_0101 << i;
      req_i = 1'b1;
      @(negedge clk);
      n_vec++; if (rvalid_o !== 1'b1 || rdata_o !== 32'h1234 || err_o !== 1'b0 || gnt_o !== 1'b0) begin n_err++;
        $display("FAIL resp_hold[%0d]: got rvalid=%0b rdata=%h err=%0b gnt=%0b exp 1/00001234/0/0",
                 i, rvalid_o, rdata_o, err_o, gnt_o); end
      @(posedge clk); #1;
    end
    req_i = 1'b0; rready_i = 1'b1;
    @(posedge clk); #1 rready_i = 1'b0;
    @(negedge clk);
    n_vec++; if (rvalid_o !== 1'b0 || dbg_state_o !== 2'd0) begin n_err++;
      $display("FAIL resp_retire: got rvalid=%0b state=%0d exp 0/0", rvalid_o, dbg_state_o); end
    @(posedge clk); #1;
    reglk_i[0] = '0; reglk_i[1] = '0;
  endtask

  task automatic test_reset_in_check();
    logic g, e; int lat; logic [31:0] rd; int seen;
    req_i = 1'b1; we_i = 1'b1; addr_i = 8'd0; wdata_i = 32'hFFFF_FFFF;
    @(posedge clk); #1 req_i = 1'b0; we_i = 1'b0; rst_ni = 1'b0;
    @(posedge clk); #1 rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); if (rvalid_o) seen++;
    end
    n_vec++; if (seen != 0) begin n_err++; $display("FAIL rst_check_resp: got %0d rvalid cycles exp 0", seen); end
    @(posedge clk); #1;
    access(1'b0, 8'd0, 32'h0, 1'b0, 32'h0, g, lat, rd, e);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_check_rd0: got %h exp 00000000", rd); end
    access(1'b0, 8'd3, 32'h0, 1'b0, 32'h0, g, lat, rd, e);
    n_vec++; if (rd !== 32'h0) begin n_err++; $display("FAIL rst_clears_regs: got %h exp 00000000", rd); end
  endtask

  task automatic test_reset_in_resp();
    logic g, e; int lat; logic [31:0] rd;
    access(1'b1, 8'd7, 32'hA5, 1'b0, 32'h0, g, lat, rd, e);
    req_i = 1'b1; we_i = 1'b0; addr_i = 8'd7;
    @(posedge clk); #1 req_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (rvalid_o !== 1'b1 || rdata_o !== 32'hA5) begin n_err++;
      $display("FAIL pre_rst_resp: got rvalid=%0b rdata=%h exp 1/000000a5", rvalid_o, rdata_o); end
    do_reset();
    @(negedge clk);
    n_vec++; if (rvalid_o !== 1'b0 || dbg_state_o !== 2'd0 || rdata_o !== 32'h0) begin n_err++;
      $display("FAIL rst_resp_drop: got rvalid=%0b state=%0d rdata=%h exp 0/0/0", rvalid_o, dbg_state_o, rdata_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_locked_write();
    test_out_of_range();
    test_lock_sample();
    test_saturation();
    test_resp_hold();
    test_reset_in_check();
    test_reset_in_resp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
